iterative_divider: RTL and testbench

Parametrised sequential divider computing quotient and remainder, one quotient bit per clock (restoring shift-subtract). It replaces the single-cycle combinational divider in stream datapaths where timing closure at wide widths matters. Each request selects unsigned or signed (truncating) mode. Full valid/ready handshake on both sides, including output backpressure.

---
 rtl/iterative_divider.sv | 194 +++++++++++++++++++
 tb/tb_iterative_divider.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Sequential restoring divider: one quotient bit per clock, unsigned or
// truncating signed division, valid/ready handshake on request and result.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             i_ready,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_payload_dividend,
  input  logic [WIDTH-1:0] i_payload_divisor,
  input  logic             i_payload_signed,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_payload_1,
  output logic [WIDTH-1:0] o_payload_2,
  output logic             o_payload_dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST      = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic             neg_quo;
  logic             neg_rem;

  logic             accept;
  logic             div_zero;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  // Two's-complement magnitude; the most negative value maps onto 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ~v + ONE;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             negate);
    if (negate) begin
      return ~v + ONE;
    end else begin
      return v;
    end
  endfunction

  assign accept    = i_valid && (state == IDLE);
  assign div_zero  = (i_payload_divisor == ALL_ZEROS);
  assign last_iter = (count == LAST);

  // One restoring step; the trial difference goes negative (top bit set) when
  // the shifted partial remainder is below the divisor.
  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    trial     = shifted - {1'b0, div_mag};
    take      = ~trial[WIDTH];
    rem_next  = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], take};
    quo_final = apply_sign(quo_next, neg_quo);
    rem_final = apply_sign(rem_next, neg_rem);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = div_zero ? DONE : BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end else begin
          state_next = BUSY;
        end
      end
      DONE: begin
        if (o_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    i_ready = 1'b0;
    o_valid = 1'b0;
    case (state)
      IDLE:    i_ready = 1'b1;
      DONE:    o_valid = 1'b1;
      default: begin
        i_ready = 1'b0;
        o_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration and result registers; results hold through DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count         <= {CW{1'b0}};
      rem           <= ALL_ZEROS;
      quo           <= ALL_ZEROS;
      div_mag       <= ALL_ZEROS;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      o_payload_1   <= ALL_ZEROS;
      o_payload_2   <= ALL_ZEROS;
      o_payload_dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count   <= {CW{1'b0}};
            rem     <= ALL_ZEROS;
            quo     <= magnitude(i_payload_dividend, i_payload_signed);
            div_mag <= magnitude(i_payload_divisor, i_payload_signed);
            neg_quo <= i_payload_signed &
                       (i_payload_dividend[WIDTH-1] ^ i_payload_divisor[WIDTH-1]);
            neg_rem <= i_payload_signed & i_payload_dividend[WIDTH-1];
            if (div_zero) begin
              o_payload_1   <= ALL_ONES;
              o_payload_2   <= ALL_ONES;
              o_payload_dbz <= 1'b1;
            end else begin
              o_payload_dbz <= o_payload_dbz;
            end
          end else begin
            count <= count;
          end
        end
        BUSY: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + CNT_ONE;
          if (last_iter) begin
            o_payload_1   <= quo_final;
            o_payload_2   <= rem_final;
            o_payload_dbz <= 1'b0;
          end else begin
            o_payload_dbz <= o_payload_dbz;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider at WIDTH=32 and WIDTH=8.
module tb_iterative_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        a_i_ready, a_i_valid, a_signed, a_o_valid, a_o_ready, a_dbz;
  logic [31:0] a_dividend, a_divisor, a_q, a_r;

  logic        b_i_ready, b_i_valid, b_signed, b_o_valid, b_o_ready, b_dbz;
  logic [7:0]  b_dividend, b_divisor, b_q, b_r;

  int errors = 0;
  int checks = 0;

  iterative_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .i_ready(a_i_ready), .i_valid(a_i_valid),
    .i_payload_dividend(a_dividend), .i_payload_divisor(a_divisor),
    .i_payload_signed(a_signed),
    .o_valid(a_o_valid), .o_ready(a_o_ready),
    .o_payload_1(a_q), .o_payload_2(a_r), .o_payload_dbz(a_dbz)
  );

  iterative_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .i_ready(b_i_ready), .i_valid(b_i_valid),
    .i_payload_dividend(b_dividend), .i_payload_divisor(b_divisor),
    .i_payload_signed(b_signed),
    .o_valid(b_o_valid), .o_ready(b_o_ready),
    .o_payload_1(b_q), .o_payload_2(b_r), .o_payload_dbz(b_dbz)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    check_value("ready32_before_req", {63'd0, a_i_ready}, 64'd1);
    a_i_valid = 1'b1; a_dividend = a; a_divisor = b; a_signed = s;
    @(posedge clk);
    #1;
    a_i_valid = 1'b0; a_dividend = $urandom; a_divisor = $urandom; a_signed = 1'b1;
  endtask

  task automatic await32(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!a_o_valid && lat < 200);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] eq, input logic [31:0] er,
                      input logic edbz, input int elat);
    int lat;
    send32(a, b, s);
    await32(lat);
    check_value({tag, "_latency"}, 64'(lat), 64'(elat));
    @(negedge clk);
    check_value({tag, "_quo"}, {32'd0, a_q}, {32'd0, eq});
    check_value({tag, "_rem"}, {32'd0, a_r}, {32'd0, er});
    check_value({tag, "_dbz"}, {63'd0, a_dbz}, {63'd0, edbz});
    a_o_ready = 1'b1;
    @(posedge clk);
    #1;
    a_o_ready = 1'b0;
    check_value({tag, "_valid_drop"}, {63'd0, a_o_valid}, 64'd0);
    check_value({tag, "_ready_back"}, {63'd0, a_i_ready}, 64'd1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [7:0] eq, input logic [7:0] er,
                     input logic edbz, input int elat);
    int lat;
    @(negedge clk);
    check_value({tag, "_ready_before"}, {63'd0, b_i_ready}, 64'd1);
    b_i_valid = 1'b1; b_dividend = a; b_divisor = b; b_signed = s;
    @(posedge clk);
    #1;
    b_i_valid = 1'b0; b_dividend = 8'h5A; b_divisor = 8'hA5; b_signed = ~s;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!b_o_valid && lat < 200);
    check_value({tag, "_latency"}, 64'(lat), 64'(elat));
    @(negedge clk);
    check_value({tag, "_quo"}, {56'd0, b_q}, {56'd0, eq});
    check_value({tag, "_rem"}, {56'd0, b_r}, {56'd0, er});
    check_value({tag, "_dbz"}, {63'd0, b_dbz}, {63'd0, edbz});
    b_o_ready = 1'b1;
    @(posedge clk);
    #1;
    b_o_ready = 1'b0;
    check_value({tag, "_valid_drop"}, {63'd0, b_o_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    a_i_valid = 1'b0; a_dividend = 32'd0; a_divisor = 32'd0; a_signed = 1'b0; a_o_ready = 1'b0;
    b_i_valid = 1'b0; b_dividend = 8'd0;  b_divisor = 8'd0;  b_signed = 1'b0; b_o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_valid32", {63'd0, a_o_valid}, 64'd0);
    check_value("rst_quo32", {32'd0, a_q}, 64'd0);
    check_value("rst_rem32", {32'd0, a_r}, 64'd0);
    check_value("rst_dbz32", {63'd0, a_dbz}, 64'd0);
    check_value("rst_ready32", {63'd0, a_i_ready}, 64'd1);
    check_value("rst_valid8", {63'd0, b_o_valid}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    op32("u17_5",     32'd17,         32'd5,          1'b0, 32'd3,          32'd2,          1'b0, 32);
    op32("umax_1",    32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 32);
    op32("u7_9",      32'd7,          32'd9,          1'b0, 32'd0,          32'd7,          1'b0, 32);
    op32("u_negbits", 32'hFFFFFFEF,   32'd5,          1'b0, 32'h3333332F,   32'd4,          1'b0, 32);
    op32("dbz_u",     32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 1);
    op32("dbz_s",     32'h1234,       32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 1);
    op32("s_n17_5",   32'hFFFFFFEF,   32'd5,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFE,   1'b0, 32);
    op32("s_17_n5",   32'd17,         32'hFFFFFFFB,   1'b1, 32'hFFFFFFFD,   32'd2,          1'b0, 32);
    op32("s_n17_n5",  32'hFFFFFFEF,   32'hFFFFFFFB,   1'b1, 32'd3,          32'hFFFFFFFE,   1'b0, 32);
    op32("s_ovf",     32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 32);
    op32("s_n20_5",   32'hFFFFFFEC,   32'd5,          1'b1, 32'hFFFFFFFC,   32'd0,          1'b0, 32);

    // Output backpressure with input noise.
    send32(32'd1000, 32'd7, 1'b0);
    await32(lat);
    check_value("bp_latency", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_i_valid = i[0]; a_dividend = $urandom; a_divisor = $urandom; a_signed = i[1];
      check_value("bp_valid", {63'd0, a_o_valid}, 64'd1);
      check_value("bp_ready", {63'd0, a_i_ready}, 64'd0);
      check_value("bp_quo", {32'd0, a_q}, 64'd142);
      check_value("bp_rem", {32'd0, a_r}, 64'd6);
      check_value("bp_dbz", {63'd0, a_dbz}, 64'd0);
    end
    @(negedge clk);
    a_i_valid = 1'b0;
    a_o_ready = 1'b1;
    @(posedge clk);
    #1;
    a_o_ready = 1'b0;
    check_value("bp_release_valid", {63'd0, a_o_valid}, 64'd0);
    check_value("bp_release_ready", {63'd0, a_i_ready}, 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check_value("bp_no_extra_valid", {63'd0, a_o_valid}, 64'd0);
    check_value("bp_still_ready", {63'd0, a_i_ready}, 64'd1);

    // Reset in the middle of an iteration run.
    send32(32'd5000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_value("mid_rst_valid", {63'd0, a_o_valid}, 64'd0);
    check_value("mid_rst_quo", {32'd0, a_q}, 64'd0);
    check_value("mid_rst_rem", {32'd0, a_r}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_value("post_rst_ready", {63'd0, a_i_ready}, 64'd1);
    repeat (40) @(posedge clk);
    #1;
    check_value("post_rst_no_valid", {63'd0, a_o_valid}, 64'd0);
    op32("post_rst_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);

    op8("w8_200_3", 8'd200, 8'd3,  1'b0, 8'd66,  8'd2,  1'b0, 8);
    op8("w8_ovf",   8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0, 8);
    op8("w8_n7_2",  8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0, 8);
    op8("w8_dbz",   8'h34,  8'h00, 1'b0, 8'hFF,  8'hFF, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
